// File: rtl/sram_client_sequencer.sv
// SRAM ownership sequencer: launches clients 1..NUM_CLIENTS-1 in order and muxes their SRAM requests.
// Client 0 owns the port when idle. Define SEQ_LOOP_EN to restart the chain after each pass.
module sram_client_sequencer #(
    parameter int  NUM_CLIENTS = 4,
    parameter int  ADDR_W      = 18,
    parameter int  DATA_W      = 16,
    parameter int  TIMEOUT_W   = 26,
    localparam int CW          = $clog2(NUM_CLIENTS)
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Start,
    input  logic                          Abort,
    input  logic [TIMEOUT_W-1:0]          Timeout_limit,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] Client_address,
    input  logic [NUM_CLIENTS*DATA_W-1:0] Client_write_data,
    input  logic [NUM_CLIENTS-1:0]        Client_we_n,
    input  logic [NUM_CLIENTS-1:0]        Client_done,
    output logic [NUM_CLIENTS-1:0]        Client_enable,
    output logic [NUM_CLIENTS-1:0]        Client_start,
    output logic [ADDR_W-1:0]             SRAM_address,
    output logic [DATA_W-1:0]             SRAM_write_data,
    output logic                          SRAM_we_n,
    output logic [CW-1:0]                 Active_client,
    output logic                          Busy,
    output logic                          Sequence_done,
    output logic [NUM_CLIENTS-1:0]        Timeout_error
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_FINISH} state_t;

    localparam logic [CW-1:0]          FIRST_K = CW'(1);
    localparam logic [CW-1:0]          LAST_K  = CW'(NUM_CLIENTS - 1);
    localparam logic [NUM_CLIENTS-1:0] ONE     = NUM_CLIENTS'(1);

    state_t                 state, state_nx;
    logic [CW-1:0]          k, k_nx;
    logic [TIMEOUT_W-1:0]   cnt, cnt_nx;
    logic [NUM_CLIENTS-1:0] terr_nx;
    logic                   phase_end;
    logic                   owning;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_nx  = state;
        k_nx      = k;
        cnt_nx    = cnt;
        terr_nx   = Timeout_error;
        phase_end = 1'b0;

        case (state)
            S_IDLE: begin
                if (Start && !Abort) begin
                    k_nx     = FIRST_K;
                    terr_nx  = '0;
                    state_nx = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_nx   = '0;
                state_nx = S_RUN;
            end
            S_RUN: begin
                // Done beats timeout; the counter measures cycles since the last write request.
                if (Client_done[k]) begin
                    phase_end = 1'b1;
                end else if ((Timeout_limit != '0) && (cnt == Timeout_limit)) begin
                    terr_nx[k] = 1'b1;
                    phase_end  = 1'b1;
                end else if (!Client_we_n[k]) begin
                    cnt_nx = '0;
                end else if (cnt != '1) begin
                    cnt_nx = cnt + 1'b1;
                end

                if (phase_end) begin
                    if (k < LAST_K) begin
                        k_nx     = k + 1'b1;
                        state_nx = S_LAUNCH;
                    end else begin
                        state_nx = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
`ifdef SEQ_LOOP_EN
                k_nx     = FIRST_K;
                terr_nx  = '0;
                state_nx = S_LAUNCH;
`else
                state_nx = S_IDLE;
`endif
            end
            default: state_nx = S_IDLE;
        endcase

        // Abort outranks completion and timeout, and leaves the error record untouched.
        if (Abort && (state != S_IDLE)) begin
            state_nx = S_IDLE;
            terr_nx  = Timeout_error;
        end
    end

    assign owning = (state_nx == S_LAUNCH) || (state_nx == S_RUN);

    always_ff @(posedge Clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values together.
        if (Reset) begin
            state         <= S_IDLE;
            k             <= FIRST_K;
            cnt           <= '0;
            Timeout_error <= '0;
            Client_enable <= '0;
            Client_start  <= '0;
            Active_client <= '0;
            Sequence_done <= 1'b0;
        end else begin
            state         <= state_nx;
            k             <= k_nx;
            cnt           <= cnt_nx;
            Timeout_error <= terr_nx;
            Client_enable <= owning ? (ONE << k_nx) : '0;
            Client_start  <= (state_nx == S_LAUNCH) ? (ONE << k_nx) : '0;
            Active_client <= owning ? k_nx : '0;
            Sequence_done <= (state_nx == S_FINISH);
        end
    end

    assign Busy            = (state != S_IDLE);
    assign SRAM_address    = Client_address[int'(Active_client) * ADDR_W +: ADDR_W];
    assign SRAM_write_data = Client_write_data[int'(Active_client) * DATA_W +: DATA_W];
    assign SRAM_we_n       = (Active_client == '0) ? 1'b1 : Client_we_n[Active_client];

endmodule

// File: tb/tb_sram_client_sequencer.sv
// Directed bench for sram_client_sequencer: behavioural clients answer Client_start,
// and a scoreboard of expected launch/completion events is checked as they appear.
module tb_sram_client_sequencer;

    localparam int NC = 4;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int TW = 26;
    localparam int CW = 2;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              Start;
    logic              Abort;
    logic [TW-1:0]     Timeout_limit;
    logic [NC*AW-1:0]  Client_address;
    logic [NC*DW-1:0]  Client_write_data;
    logic [NC-1:0]     Client_we_n;
    logic [NC-1:0]     Client_done;
    logic [NC-1:0]     Client_enable;
    logic [NC-1:0]     Client_start;
    logic [AW-1:0]     SRAM_address;
    logic [DW-1:0]     SRAM_write_data;
    logic              SRAM_we_n;
    logic [CW-1:0]     Active_client;
    logic              Busy;
    logic              Sequence_done;
    logic [NC-1:0]     Timeout_error;

    sram_client_sequencer #(
        .NUM_CLIENTS(NC), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(TW)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort),
        .Timeout_limit(Timeout_limit), .Client_address(Client_address),
        .Client_write_data(Client_write_data), .Client_we_n(Client_we_n),
        .Client_done(Client_done), .Client_enable(Client_enable),
        .Client_start(Client_start), .SRAM_address(SRAM_address),
        .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
        .Active_client(Active_client), .Busy(Busy),
        .Sequence_done(Sequence_done), .Timeout_error(Timeout_error)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int            kind;   // 0: Client_start pulse, 1: Sequence_done pulse
        int            idx;
        int            cyc;
        logic [NC-1:0] terr;
    } ev_t;

    ev_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] addr_tbl [NC];
    logic [DW-1:0] data_tbl [NC];
    int            dly [NC];   // done raised this many cycles after the start pulse; <1 never
    int            wl  [NC];   // we_n held low for this many RUN cycles after launch
    logic [NC-1:0] done_v;
    logic [NC-1:0] we_v;
    logic          spur;
    logic          we0;

    assign Client_done = done_v | {spur, {(NC-1){1'b0}}};
    assign Client_we_n = {we_v[NC-1:1], we0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int idx, input int c, input logic [NC-1:0] terr);
        ev_t e;
        e.kind = kind;
        e.idx  = idx;
        e.cyc  = c;
        e.terr = terr;
        sb.push_back(e);
    endtask

    task automatic expect_event(input int kind, input int idx, output bit ok, output ev_t e);
        ok = (sb.size() > 0);
        check("event_expected", ok, 1'b1);
        e.kind = -1;
        e.idx  = -1;
        e.cyc  = -1;
        e.terr = '0;
        if (ok) begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            check("event_client", idx, e.idx);
            check("event_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor first (before client inputs move), then the behavioural clients.
    initial begin
        int   st [NC];
        bit   armed [NC];
        bit   ok;
        ev_t  e;
        done_v = '0;
        we_v   = '1;
        for (int i = 0; i < NC; i++) armed[i] = 1'b0;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                done_v = '0;
                we_v   = '1;
                for (int i = 0; i < NC; i++) armed[i] = 1'b0;
            end else begin
                for (int i = 1; i < NC; i++) begin
                    if (Client_start[i]) begin
                        expect_event(0, i, ok, e);
                        check("start_active", Active_client, i);
                        check("start_enable", Client_enable, 64'(1) << i);
                        check("sram_address", SRAM_address, addr_tbl[i]);
                        check("sram_wdata", SRAM_write_data, data_tbl[i]);
                        check("sram_we_n", SRAM_we_n, Client_we_n[i]);
                    end
                end
                if (Sequence_done) begin
                    expect_event(1, 0, ok, e);
                    if (ok) check("done_terr", Timeout_error, e.terr);
                    check("done_enable", Client_enable, 0);
                end
                for (int i = 1; i < NC; i++) begin
                    if (Client_start[i]) begin
                        armed[i] = 1'b1;
                        st[i]    = cyc;
                    end else if (!Client_enable[i]) begin
                        armed[i] = 1'b0;
                    end
                    done_v[i] = armed[i] && (dly[i] >= 1) && (cyc == st[i] + dly[i]);
                    if (done_v[i]) armed[i] = 1'b0;
                    we_v[i] = !(armed[i] && (cyc >= st[i] + 1) && (cyc <= st[i] + wl[i]));
                end
            end
        end
    end

    task automatic set_client(input int i, input int d, input int w);
        dly[i] = d;
        wl[i]  = w;
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 2000 && cyc < target; i++) @(negedge Clock);
        check("wait_until", cyc, target);
    endtask

    // Phase length from launch to next launch/finish: done after d+1 cycles,
    // timeout after w + limit + 2 cycles (counter starts at 0 on the first RUN cycle).
    function automatic void phase_len(input int d, input int w, input int lim,
                                      output int len, output bit to);
        int dl;
        int tl;
        dl  = (d >= 1) ? d + 1 : 1 << 30;
        tl  = (lim != 0) ? w + lim + 2 : 1 << 30;
        to  = tl < dl;
        len = to ? tl : dl;
    endfunction

    task automatic run_seq(input int lim, input int abort_k, input int abort_off, input bit noise);
        int            s [NC];
        int            len;
        int            t_end;
        bit            to;
        logic [NC-1:0] terr;
        logic [NC-1:0] terr_pre;
        Timeout_limit = TW'(lim);
        terr     = '0;
        terr_pre = '0;
        t_end    = 0;
        s[1]     = cyc + 1;
        for (int k = 1; k < NC; k++) begin
            phase_len(dly[k], wl[k], lim, len, to);
            if (to) terr[k] = 1'b1;
            if (to && k < abort_k) terr_pre[k] = 1'b1;
            if (k < NC - 1) s[k+1] = s[k] + len;
            else t_end = s[k] + len;
        end
        for (int k = 1; k < NC; k++)
            if (abort_k == 0 || k <= abort_k) push_ev(0, k, s[k], '0);
        if (abort_k == 0) push_ev(1, 0, t_end, terr);

        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        if (noise) begin
            wait_until(s[1] + 2);
            Start = 1'b1;
            spur  = 1'b1;
            @(negedge Clock);
            Start = 1'b0;
            spur  = 1'b0;
        end
        if (abort_k != 0) begin
            wait_until(s[abort_k] + abort_off);
            Abort = 1'b1;
            @(negedge Clock);
            Abort = 1'b0;
            check("abort_busy", Busy, 0);
            check("abort_enable", Client_enable, 0);
            check("abort_start", Client_start, 0);
            check("abort_active", Active_client, 0);
            check("abort_seq_done", Sequence_done, 0);
            check("abort_terr", Timeout_error, terr_pre);
            repeat (10) @(negedge Clock);
        end else begin
            wait_until(t_end + 1);
            check("end_busy", Busy, 0);
            check("end_enable", Client_enable, 0);
            check("end_active", Active_client, 0);
        end
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Abort = 1'b0;
        spur  = 1'b0;
        we0   = 1'b0;
        Timeout_limit = '0;
        for (int i = 0; i < NC; i++) begin
            addr_tbl[i] = AW'('h0A5A0 + i * 'h1357);
            data_tbl[i] = DW'('hC000 + i * 'h0F0F);
            Client_address[i*AW +: AW]    = addr_tbl[i];
            Client_write_data[i*DW +: DW] = data_tbl[i];
            set_client(i, 5, 0);
        end
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);

        check("rst_enable", Client_enable, 0);
        check("rst_start", Client_start, 0);
        check("rst_active", Active_client, 0);
        check("rst_busy", Busy, 0);
        check("rst_seq_done", Sequence_done, 0);
        check("rst_terr", Timeout_error, 0);
        check("rst_sram_address", SRAM_address, addr_tbl[0]);
        check("rst_sram_wdata", SRAM_write_data, data_tbl[0]);
        check("rst_sram_we_n", SRAM_we_n, 1'b1);

`ifdef SEQ_LOOP_EN
        begin : loop_test
            int base;
            for (int i = 1; i < NC; i++) set_client(i, 1, 0);
            Timeout_limit = '0;
            base = cyc + 1;
            for (int l = 0; l < 3; l++) begin
                push_ev(0, 1, base, '0);
                push_ev(0, 2, base + 2, '0);
                push_ev(0, 3, base + 4, '0);
                push_ev(1, 0, base + 6, '0);
                base += 7;
            end
            push_ev(0, 1, base, '0);
            Start = 1'b1;
            @(negedge Clock);
            Start = 1'b0;
            wait_until(base);
            Abort = 1'b1;
            @(negedge Clock);
            Abort = 1'b0;
            check("loop_abort_busy", Busy, 0);
            check("loop_abort_enable", Client_enable, 0);
            repeat (10) @(negedge Clock);
            check("loop_sb_drained", sb.size(), 0);
        end
`else
        // Nominal pass: each client done 5 cycles after its start pulse.
        for (int i = 1; i < NC; i++) set_client(i, 5, 0);
        run_seq(0, 0, 0, 1'b0);

        // Client 2 holds we_n low for 3 RUN cycles, then idles until timeout.
        set_client(1, 3, 0);
        set_client(2, -1, 3);
        set_client(3, 2, 0);
        run_seq(10, 0, 0, 1'b0);

        // Done and timeout on the same edge; Start and a stray done[3] during phase 1.
        set_client(1, 6, 0);
        set_client(2, 11, 0);
        set_client(3, 1, 0);
        run_seq(10, 0, 0, 1'b1);

        // Client 1 times out, then Abort during client 2.
        set_client(1, -1, 0);
        set_client(2, -1, 0);
        set_client(3, 1, 0);
        run_seq(4, 2, 3, 1'b0);

        // Start together with Abort while idle must not launch anything.
        Start = 1'b1;
        Abort = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        Abort = 1'b0;
        check("start_abort_busy", Busy, 0);
        @(negedge Clock);
        check("start_abort_busy2", Busy, 0);
        check("start_abort_enable", Client_enable, 0);
`endif

        check("final_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
